risc_ctrl: RTL and testbench

RISC_CTRL -- requirements
Module: risc_ctrl

---
 rtl/risc_pkg.sv | 16 +
 rtl/risc_ctrl_pipe_valid.sv | 22 ++
 rtl/risc_ctrl.sv | 84 ++++++++
 tb/tb_risc_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared state encoding and width constants for the RISC control slice.
package risc_pkg;

  localparam int unsigned IMW = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned IW  = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/risc_ctrl_pipe_valid.sv
// Valid-bit shift register tracking which pipeline stages hold a real instruction.
module pipe_valid #(
  parameter int unsigned PIPE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in,
  output logic [PIPE_DEPTH-1:0] v
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v <= '0;
    end else begin
      v[0] <= in;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
        v[i] <= v[i-1];
      end
    end
  end

endmodule

// File: rtl/risc_ctrl.sv
// Fetch/write-back sequencer: clears the register file, fetches up to end_addr,
// drains the pipeline and counts retired instructions. RST_CYC must be >= 1.
module risc_ctrl #(
  parameter int unsigned IMW        = risc_pkg::IMW,
  parameter int unsigned PIPE_DEPTH = 4,
  parameter int unsigned RST_CYC    = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           stall,
  input  logic           halt_req,
  input  logic [IMW-1:0] end_addr,
  output logic [IMW-1:0] pc_out,
  output logic           im_cs,
  output logic           rf_we,
  output logic           rf_reset,
  output logic           busy,
  output logic           done,
  output logic [7:0]     retired
);

  import risc_pkg::*;

  localparam int unsigned CW = $clog2(RST_CYC + 1);

  state_t                state_q, state_d;
  logic [IMW-1:0]        pc_q;
  logic [CW-1:0]         clr_q;
  logic [PIPE_DEPTH-1:0] v;
  logic                  fetch;

  assign fetch = (state_q == RUN) && !stall && !halt_req;

  pipe_valid #(.PIPE_DEPTH(PIPE_DEPTH)) u_pipe_valid (
    .clk   (clk),
    .reset (reset),
    .in    (fetch),
    .v     (v)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CLR;
      CLR:     if (clr_q == '0) state_d = RUN;
      RUN: begin
        if (halt_req)                       state_d = DRAIN;
        else if (fetch && pc_q == end_addr) state_d = DRAIN;
      end
      DRAIN:   if (v == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      clr_q   <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (fetch) pc_q <= pc_q + 1'b1;
      if (state_q == CLR && clr_q != '0) clr_q <= clr_q - 1'b1;
      if (rf_we && retired != 8'hFF) retired <= retired + 8'd1;
      // A new run takes precedence; the pipe is empty in IDLE so no write-back is lost.
      if (state_q == IDLE && start) begin
        pc_q    <= '0;
        retired <= '0;
        clr_q   <= CW'(RST_CYC - 1);
      end
    end
  end

  assign pc_out   = pc_q;
  assign im_cs    = fetch;
  assign rf_we    = v[PIPE_DEPTH-1];
  assign rf_reset = (state_q == CLR);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_risc_ctrl.sv
// Directed bench for risc_ctrl: cycle-by-cycle vector table plus halt, wrap,
// saturation and asynchronous-reset sequences.
module tb_risc_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stall, halt_req;
  logic [3:0] end_addr;
  logic [3:0] pc_out;
  logic       im_cs, rf_we, rf_reset, busy, done;
  logic [7:0] retired;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  risc_ctrl #(.IMW(4), .PIPE_DEPTH(4), .RST_CYC(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stall    (stall),
    .halt_req (halt_req),
    .end_addr (end_addr),
    .pc_out   (pc_out),
    .im_cs    (im_cs),
    .rf_we    (rf_we),
    .rf_reset (rf_reset),
    .busy     (busy),
    .done     (done),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, sl, hl;
    logic [3:0] ea;
    logic       im;
    logic [3:0] pc;
    logic       we, rr, bs, dn;
    logic [7:0] ret;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, sl, hl, input logic [3:0] ea,
                              input logic im, input logic [3:0] pc,
                              input logic we, rr, bs, dn, input logic [7:0] ret);
    vec_t r;
    r.st = st; r.sl = sl; r.hl = hl; r.ea = ea;
    r.im = im; r.pc = pc; r.we = we; r.rr = rr; r.bs = bs; r.dn = dn; r.ret = ret;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one program with end_addr steered away from the model pc until
  // 'target' fetches have occurred, then aimed at the next fetch.
  task automatic run_dyn(input int unsigned target, input bit pulse_start,
                         output int unsigned fetches, output bit seq_ok,
                         output bit got_done, output int unsigned span,
                         output logic [7:0] ret_at_done);
    logic [3:0]  exp_pc;
    int unsigned first_c, last_c;
    exp_pc = 4'd0; fetches = 0; seq_ok = 1'b1; got_done = 1'b0;
    first_c = 0; last_c = 0; ret_at_done = 8'hxx;
    stall = 1'b0; halt_req = 1'b0;
    for (int unsigned c = 0; c < 600; c++) begin
      start    = (c == 0) || (pulse_start && c >= 3 && (c % 7) == 3);
      end_addr = (fetches >= target) ? exp_pc : 4'(exp_pc + 4'd8);
      @(negedge clk);
      if (im_cs) begin
        if (pc_out !== exp_pc) seq_ok = 1'b0;
        if (fetches == 0) first_c = c;
        last_c = c;
        exp_pc = exp_pc + 4'd1;
        fetches++;
      end
      if (done) begin
        got_done = 1'b1;
        ret_at_done = retired;
        tick;
        break;
      end
      tick;
    end
    start = 1'b0;
    span = last_c - first_c + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned fetches, span, we_cnt, extra, dl, bad;
    bit          seq_ok, got_done;
    logic [7:0]  ret_d;

    reset = 1'b1; start = 1'b0; stall = 1'b0; halt_req = 1'b0; end_addr = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {pc_out, im_cs, rf_we, rf_reset, busy, done, retired}, '0);
    @(negedge clk);
    reset = 1'b0;
    tick;

    // Basic run (end_addr=3), with ignored stall in CLR, start in RUN, halt in DRAIN.
    tbl.push_back(mk(1,0,0,3, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,3, 0,0,0,1,1,0,0));
    tbl.push_back(mk(0,0,0,3, 0,0,0,1,1,0,0));
    tbl.push_back(mk(0,0,0,3, 1,0,0,0,1,0,0));
    tbl.push_back(mk(1,0,0,3, 1,1,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,3, 1,2,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,3, 1,3,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,3, 0,4,1,0,1,0,0));
    tbl.push_back(mk(0,0,1,3, 0,4,1,0,1,0,1));
    tbl.push_back(mk(0,0,0,3, 0,4,1,0,1,0,2));
    tbl.push_back(mk(0,0,0,3, 0,4,1,0,1,0,3));
    tbl.push_back(mk(0,0,0,3, 0,4,0,0,1,0,4));
    tbl.push_back(mk(0,0,0,3, 0,4,0,0,1,1,4));
    tbl.push_back(mk(0,0,0,3, 0,4,0,0,0,0,4));
    // Stall for two cycles after the fetch of pc=1.
    tbl.push_back(mk(1,0,0,3, 0,4,0,0,0,0,4));
    tbl.push_back(mk(0,0,0,3, 0,0,0,1,1,0,0));
    tbl.push_back(mk(0,0,0,3, 0,0,0,1,1,0,0));
    tbl.push_back(mk(0,0,0,3, 1,0,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,3, 1,1,0,0,1,0,0));
    tbl.push_back(mk(0,1,0,3, 0,2,0,0,1,0,0));
    tbl.push_back(mk(0,1,0,3, 0,2,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,3, 1,2,1,0,1,0,0));
    tbl.push_back(mk(0,0,0,3, 1,3,1,0,1,0,1));
    tbl.push_back(mk(0,0,0,3, 0,4,0,0,1,0,2));
    tbl.push_back(mk(0,0,0,3, 0,4,0,0,1,0,2));
    tbl.push_back(mk(0,0,0,3, 0,4,1,0,1,0,2));
    tbl.push_back(mk(0,0,0,3, 0,4,1,0,1,0,3));
    tbl.push_back(mk(0,0,0,3, 0,4,0,0,1,0,4));
    tbl.push_back(mk(0,0,0,3, 0,4,0,0,1,1,4));
    tbl.push_back(mk(0,0,0,3, 0,4,0,0,0,0,4));

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].st; stall = tbl[i].sl; halt_req = tbl[i].hl; end_addr = tbl[i].ea;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {im_cs, pc_out, rf_we, rf_reset, busy, done, retired},
          {tbl[i].im, tbl[i].pc, tbl[i].we, tbl[i].rr, tbl[i].bs, tbl[i].dn, tbl[i].ret});
      tick;
    end
    start = 1'b0; stall = 1'b0; halt_req = 1'b0;

    // Halt after the fetch of pc=5 with end_addr=15; stall asserted too.
    fetches = 0; we_cnt = 0; seq_ok = 1'b1; extra = 0; dl = 0;
    start = 1'b1; end_addr = 4'd15;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (im_cs) begin
        if (pc_out !== 4'(fetches)) seq_ok = 1'b0;
        fetches++;
      end
      if (rf_we) we_cnt++;
      tick;
      start = 1'b0;
      if (fetches == 6) break;
    end
    halt_req = 1'b1; stall = 1'b1;
    @(negedge clk);
    chk("halt_cycle_im_cs", im_cs, 1'b0);
    if (rf_we) we_cnt++;
    tick;
    halt_req = 1'b0; stall = 1'b0;
    for (int d = 1; d <= 20; d++) begin
      @(negedge clk);
      if (im_cs) extra++;
      if (rf_we) we_cnt++;
      if (done) begin dl = d; break; end
      tick;
    end
    chk("halt_fetches", fetches, 6);
    chk("halt_fetch_seq", seq_ok, 1'b1);
    chk("halt_no_fetch_after", extra, 0);
    chk("halt_done_delay", dl, 5);
    chk("halt_rf_we_count", we_cnt, 6);
    tick;
    @(negedge clk);
    chk("halt_retired", retired, 8'd6);
    chk("halt_idle", busy, 1'b0);
    tick;

    // pc wraps 15 -> 0 without a gap; run ends at pc=3 after 20 fetches.
    run_dyn(19, 1'b0, fetches, seq_ok, got_done, span, ret_d);
    chk("wrap_done", got_done, 1'b1);
    chk("wrap_fetches", fetches, 20);
    chk("wrap_pc_seq", seq_ok, 1'b1);
    chk("wrap_no_gap", span, 20);
    chk("wrap_retired", ret_d, 8'd20);

    // 301 fetches with start pulses during the run: retired saturates.
    run_dyn(300, 1'b1, fetches, seq_ok, got_done, span, ret_d);
    chk("sat_done", got_done, 1'b1);
    chk("sat_fetches", fetches, 301);
    chk("sat_pc_seq", seq_ok, 1'b1);
    chk("sat_retired", ret_d, 8'd255);

    // Asynchronous reset during the third RUN cycle.
    start = 1'b1; end_addr = 4'd15;
    tick;
    start = 1'b0;
    repeat (4) tick;
    chk("prereset_run", {im_cs, busy, pc_out}, {1'b1, 1'b1, 4'd2});
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {pc_out, im_cs, rf_we, rf_reset, busy, done, retired}, '0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rf_we || busy || im_cs || done) bad++;
    end
    chk("post_reset_quiet", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
